// File: rtl/int2str_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// with signed mode, overflow saturation and significant-digit count.
module int2str_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5,
  parameter int unsigned DW     = $clog2(DIGITS + 1)
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  input  logic                  iStart,
  input  logic                  iSigned,
  input  logic [WIDTH-1:0]      iBinary,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [4*DIGITS-1:0]   oBcd,
  output logic                  oNeg,
  output logic                  oOverflow,
  output logic [DW-1:0]         oDigits
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

  stateT            state;
  logic [WIDTH-1:0] shiftReg;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    accAdj;
  logic [CW-1:0]    bitCnt;
  logic             negPend;
  logic             ovfSticky;
  logic [DW-1:0]    sigDigits;

  // Add-3 correction on every digit that would exceed 9 after doubling
  always_comb begin
    accAdj = acc;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (acc[4*d +: 4] >= 4'd5) accAdj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  // Position of the highest non-zero digit; zero reads as one digit
  always_comb begin
    sigDigits = DW'(1);
    for (int d = 1; d < int'(DIGITS); d++) begin
      if (acc[4*d +: 4] != 4'd0) sigDigits = DW'(d + 1);
    end
    if (ovfSticky) sigDigits = DW'(DIGITS);
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state     <= IDLE;
      shiftReg  <= '0;
      acc       <= '0;
      bitCnt    <= '0;
      negPend   <= 1'b0;
      ovfSticky <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oBcd      <= '0;
      oNeg      <= 1'b0;
      oOverflow <= 1'b0;
      oDigits   <= DW'(1);
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            shiftReg  <= (iSigned && iBinary[WIDTH-1]) ? WIDTH'(-iBinary) : iBinary;
            negPend   <= iSigned & iBinary[WIDTH-1];
            acc       <= '0;
            ovfSticky <= 1'b0;
            bitCnt    <= CW'(WIDTH);
            oBusy     <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // A carry out of the top digit means the magnitude needs more digits
          {acc, shiftReg} <= {accAdj[BW-2:0], shiftReg, 1'b0};
          ovfSticky       <= ovfSticky | accAdj[BW-1];
          bitCnt          <= bitCnt - CW'(1);
          if (bitCnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          oBcd      <= ovfSticky ? {DIGITS{4'h9}} : acc;
          oNeg      <= negPend;
          oOverflow <= ovfSticky;
          oDigits   <= sigDigits;
          oDone     <= 1'b1;
          oBusy     <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int2str_seq.sv
// Bench for int2str_seq: decimal reference model plus directed vectors on a
// default instance (16 bits, 5 digits) and a 4-digit instance for saturation.
module tb_int2str_seq;

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
    logic [2:0]  dig;
  } expT;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic        aStart = 1'b0, aSgn = 1'b0;
  logic [15:0] aBin = '0;
  logic        aBusy, aDone, aNeg, aOvf;
  logic [19:0] aBcd;
  logic [2:0]  aDig;

  logic        bStart = 1'b0, bSgn = 1'b0;
  logic [15:0] bBin = '0;
  logic        bBusy, bDone, bNeg, bOvf;
  logic [15:0] bBcd;
  logic [2:0]  bDig;

  int nCmp = 0;
  int nFail = 0;
  expT qA[$];
  expT qB[$];

  int_seq_dummy_guard: assert property (@(posedge clk) 1'b1);

  int2str_seq dutA (
    .iClock(clk), .iReset_n(rstN), .iStart(aStart), .iSigned(aSgn), .iBinary(aBin),
    .oBusy(aBusy), .oDone(aDone), .oBcd(aBcd), .oNeg(aNeg), .oOverflow(aOvf), .oDigits(aDig)
  );

  int2str_seq #(.WIDTH(16), .DIGITS(4)) dutB (
    .iClock(clk), .iReset_n(rstN), .iStart(bStart), .iSigned(bSgn), .iBinary(bBin),
    .oBusy(bBusy), .oDone(bDone), .oBcd(bBcd), .oNeg(bNeg), .oOverflow(bOvf), .oDigits(bDig)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: magnitude via integer arithmetic, digits via /10 and %10
  function automatic expT model(input logic [15:0] v, input logic s, input int width, input int digits);
    expT    e;
    longint mag, lim, p;
    int     dv;
    e = '0;
    e.neg = s && v[width-1];
    mag = longint'(v) & ((longint'(1) << width) - 1);
    if (e.neg) mag = (longint'(1) << width) - mag;
    lim = 1;
    for (int d = 0; d < digits; d++) lim = lim * 10;
    e.ovf = (mag >= lim);
    e.dig = 3'd1;
    p = 1;
    for (int d = 0; d < digits; d++) begin
      dv = e.ovf ? 9 : int'((mag / p) % 10);
      e.bcd[4*d +: 4] = 4'(dv);
      if (dv != 0) e.dig = 3'(d + 1);
      p = p * 10;
    end
    if (e.ovf) e.dig = 3'(digits);
    return e;
  endfunction

  // Every oDone is matched against the next queued expectation
  always @(negedge clk) begin
    expT e;
    if (rstN && aDone) begin
      if (qA.size() == 0) chk("A_spurious_done", 32'd1, 32'd0);
      else begin
        e = qA.pop_front();
        chk("A_bcd", 32'(aBcd), 32'(e.bcd));
        chk("A_neg", 32'(aNeg), 32'(e.neg));
        chk("A_ovf", 32'(aOvf), 32'(e.ovf));
        chk("A_dig", 32'(aDig), 32'(e.dig));
      end
    end
    if (rstN && bDone) begin
      if (qB.size() == 0) chk("B_spurious_done", 32'd1, 32'd0);
      else begin
        e = qB.pop_front();
        chk("B_bcd", 32'(bBcd), 32'(e.bcd[15:0]));
        chk("B_neg", 32'(bNeg), 32'(e.neg));
        chk("B_ovf", 32'(bOvf), 32'(e.ovf));
        chk("B_dig", 32'(bDig), 32'(e.dig));
      end
    end
  end

  // One conversion; poke>0 fires an ignored iStart (777) that many cycles in
  task automatic conv(input bit useB, input logic [15:0] v, input logic s, input int poke);
    int n;
    bit seen;
    @(negedge clk);
    if (useB) begin
      bStart = 1'b1; bBin = v; bSgn = s; qB.push_back(model(v, s, 16, 4));
    end else begin
      aStart = 1'b1; aBin = v; aSgn = s; qA.push_back(model(v, s, 16, 5));
    end
    @(negedge clk);
    chk("busy_after_accept", 32'(useB ? bBusy : aBusy), 32'd1);
    aStart = 1'b0; bStart = 1'b0;
    aBin = 16'($urandom); aSgn = 1'($urandom);
    bBin = 16'($urandom); bSgn = 1'($urandom);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (!useB) begin
        if (n == poke) begin aStart = 1'b1; aBin = 16'd777; aSgn = 1'b0; end
        else aStart = 1'b0;
      end
      seen = useB ? bDone : aDone;
    end
    aStart = 1'b0;
    chk("latency", 32'(n), 32'd17);
  endtask

  task automatic litA(input string name, input logic [19:0] bcd, input logic neg,
                      input logic ovf, input logic [2:0] dig);
    chk({name, "_bcd"}, 32'(aBcd), 32'(bcd));
    chk({name, "_neg"}, 32'(aNeg), 32'(neg));
    chk({name, "_ovf"}, 32'(aOvf), 32'(ovf));
    chk({name, "_dig"}, 32'(aDig), 32'(dig));
  endtask

  initial begin
    expT m;
    int  t[3];
    int  nd, cyc;

    // Pin the model against hand-computed values
    m = model(16'hFFFF, 1'b0, 16, 5);
    chk("model_65535", 32'(m.bcd), 32'h65535);
    m = model(16'hFB2E, 1'b1, 16, 5);
    chk("model_m1234", 32'({m.bcd, m.neg, m.dig}), 32'({20'h01234, 1'b1, 3'd4}));
    m = model(16'd12345, 1'b0, 16, 4);
    chk("model_sat", 32'({m.bcd[15:0], m.ovf, m.dig}), 32'({16'h9999, 1'b1, 3'd4}));

    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(aBcd), 32'd0);
    chk("rst_flags", 32'({aBusy, aDone, aNeg, aOvf}), 32'd0);
    chk("rst_dig", 32'(aDig), 32'd1);
    rstN = 1'b1;

    conv(1'b0, 16'hFFFF, 1'b0, 0);
    litA("u65535", 20'h65535, 1'b0, 1'b0, 3'd5);
    conv(1'b0, 16'hFB2E, 1'b1, 0);
    litA("m1234", 20'h01234, 1'b1, 1'b0, 3'd4);
    conv(1'b0, 16'h8000, 1'b1, 0);
    litA("m32768", 20'h32768, 1'b1, 1'b0, 3'd5);
    conv(1'b0, 16'h0000, 1'b1, 0);
    litA("zero", 20'h00000, 1'b0, 1'b0, 3'd1);

    conv(1'b1, 16'd12345, 1'b0, 0);
    chk("B_sat_lit", 32'({bBcd, bOvf, bDig}), 32'({16'h9999, 1'b1, 3'd4}));
    conv(1'b1, 16'd9999, 1'b0, 0);
    chk("B_9999_lit", 32'({bBcd, bOvf, bDig}), 32'({16'h9999, 1'b0, 3'd4}));

    // Start while busy is ignored
    conv(1'b0, 16'd42, 1'b0, 5);
    litA("i42", 20'h00042, 1'b0, 1'b0, 3'd2);
    repeat (3) @(negedge clk);
    chk("hold_bcd", 32'(aBcd), 32'h00042);
    repeat (20) @(negedge clk);

    // iStart held high: three results, 18 cycles apart
    aStart = 1'b1; aBin = 16'd100; aSgn = 1'b0;
    for (int i = 0; i < 3; i++) qA.push_back(model(16'd100, 1'b0, 16, 5));
    nd = 0; cyc = 0;
    while (nd < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (aDone) begin t[nd] = cyc; nd++; end
    end
    aStart = 1'b0;
    chk("held_count", 32'(nd), 32'd3);
    chk("held_gap1", 32'(t[1] - t[0]), 32'd18);
    chk("held_gap2", 32'(t[2] - t[1]), 32'd18);
    repeat (25) @(negedge clk);

    // Reset mid-conversion aborts with no oDone
    aStart = 1'b1; aBin = 16'd500; aSgn = 1'b0;
    @(negedge clk);
    aStart = 1'b0;
    repeat (7) @(negedge clk);
    rstN = 1'b0;
    qA.delete();
    #1;
    chk("abort_bcd", 32'(aBcd), 32'd0);
    chk("abort_flags", 32'({aBusy, aDone, aNeg, aOvf}), 32'd0);
    chk("abort_dig", 32'(aDig), 32'd1);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (25) @(negedge clk);
    conv(1'b0, 16'd500, 1'b0, 0);
    litA("i500", 20'h00500, 1'b0, 1'b0, 3'd3);

    for (int i = 0; i < 300; i++) conv(1'b0, 16'($urandom), 1'(i % 2), 0);
    for (int i = 0; i < 150; i++) conv(1'b1, 16'($urandom), 1'(i % 2), 0);
    repeat (5) @(negedge clk);
    chk("queueA_drained", 32'(qA.size()), 32'd0);
    chk("queueB_drained", 32'(qB.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
